// File: rtl/add_round_key_stage.sv
// add_round_key_stage
//   AES AddRoundKey pipeline stage placed after mixcol. Each accepted 128-bit
//   state is XORed with the round key for the block's current round and held
//   in a single output register behind a valid/ready handshake. Round keys live
//   in an 11-entry table that is loaded one entry at a time while the stage is idle.
//
//   Ports
//     i_clk, i_rst_n          clock, asynchronous active-low reset
//     i_key_wr_en/idx/data    serial key table write
//     o_key_err               one-cycle pulse when a key write is rejected
//     o_keys_ready            every table entry written since reset/flush
//     i_key_flush             clear the loaded mask
//     i_in_valid/o_in_ready   input handshake, i_in_data state from mixcol
//     o_out_valid/i_out_ready output handshake
//     o_out_data              state ^ round key
//     o_out_round             round index applied to o_out_data
//     o_out_last              o_out_round is the final round
//
//   state   | meaning
//   IDLE    | round counter at 0 and output register empty; key writes allowed
//   BUSY    | block in progress or a beat still in the output register
module add_round_key_stage #(
  parameter int DATA_W     = 128,
  parameter int NUM_ROUNDS = 10
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_key_wr_en,
  input  logic [3:0]        i_key_wr_idx,
  input  logic [DATA_W-1:0] i_key_wr_data,
  output logic              o_key_err,
  output logic              o_keys_ready,
  input  logic              i_key_flush,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out_data,
  output logic [3:0]        o_out_round,
  output logic              o_out_last
);

  localparam int         NUM_KEYS   = NUM_ROUNDS + 1;
  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t              w_state;
  logic [DATA_W-1:0]   r_key_tbl [NUM_KEYS];
  logic [NUM_KEYS-1:0] r_mask;
  logic [NUM_KEYS-1:0] w_mask_next;
  logic [3:0]          r_round_cnt;
  logic                r_keys_ready;
  logic                r_key_err;
  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_data;
  logic [3:0]          r_out_round;
  logic                r_out_last;
  logic                w_in_ready;
  logic                w_accept;
  logic                w_key_ok;
  logic                w_key_we;

  // The state is fully implied by the round counter and the output register,
  // so it is decoded rather than stored.
  always_comb begin
    w_state = ST_BUSY;
    if ((r_round_cnt == 4'd0) && !r_out_valid) w_state = ST_IDLE;
  end

  assign w_in_ready = r_keys_ready & (~r_out_valid | i_out_ready);
  assign w_accept   = i_in_valid & w_in_ready;

  assign w_key_ok = i_key_wr_en & (w_state == ST_IDLE) & (i_key_wr_idx <= LAST_ROUND);
  // A flush wins over a write in the same cycle: neither the mask nor the table changes.
  assign w_key_we = w_key_ok & ~i_key_flush;

  always_comb begin
    w_mask_next = r_mask;
    if (i_key_flush)   w_mask_next = '0;
    else if (w_key_we) w_mask_next[i_key_wr_idx] = 1'b1;
  end

  // Key storage is intentionally not reset; the mask alone says whether it is usable.
  always_ff @(posedge i_clk) begin
    if (w_key_we) r_key_tbl[i_key_wr_idx] <= i_key_wr_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mask       <= '0;
      r_keys_ready <= 1'b0;
      r_key_err    <= 1'b0;
    end else begin
      r_mask       <= w_mask_next;
      r_keys_ready <= &w_mask_next;
      r_key_err    <= i_key_wr_en & ~w_key_ok;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_round_cnt <= 4'd0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_round <= 4'd0;
      r_out_last  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_data  <= i_in_data ^ r_key_tbl[r_round_cnt];
        r_out_round <= r_round_cnt;
        r_out_last  <= (r_round_cnt == LAST_ROUND);
        r_round_cnt <= (r_round_cnt == LAST_ROUND) ? 4'd0 : r_round_cnt + 4'd1;
      end else if (i_out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign o_in_ready   = w_in_ready;
  assign o_key_err    = r_key_err;
  assign o_keys_ready = r_keys_ready;
  assign o_out_valid  = r_out_valid;
  assign o_out_data   = r_out_data;
  assign o_out_round  = r_out_round;
  assign o_out_last   = r_out_last;

endmodule

// File: tb/tb_add_round_key_stage.sv
// Bench for add_round_key_stage: random states and keys checked against a
// queue-based model of the key table, loaded mask and round sequence.
module tb_add_round_key_stage;

  localparam logic [127:0] KEY1    = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] VEC_IN  = 128'h5f72641557f5bc92f7be3b291db9f91a;
  localparam logic [127:0] VEC_OUT = 128'hff889a02dfa19023d41d021037d58f1f;

  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b1;
  logic         i_key_wr_en = 1'b0;
  logic [3:0]   i_key_wr_idx = 4'd0;
  logic [127:0] i_key_wr_data = '0;
  logic         o_key_err;
  logic         o_keys_ready;
  logic         i_key_flush = 1'b0;
  logic         i_in_valid = 1'b0;
  logic         o_in_ready;
  logic [127:0] i_in_data = '0;
  logic         o_out_valid;
  logic         i_out_ready = 1'b0;
  logic [127:0] o_out_data;
  logic [3:0]   o_out_round;
  logic         o_out_last;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [127:0] d;
    int           r;
  } beat_t;

  logic [127:0] m_key [11];
  logic [10:0]  m_mask = '0;
  bit           m_keys_ready = 1'b0;
  int           m_round = 0;
  beat_t        q[$];

  add_round_key_stage #(.DATA_W(128), .NUM_ROUNDS(10)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_key_wr_en(i_key_wr_en), .i_key_wr_idx(i_key_wr_idx), .i_key_wr_data(i_key_wr_data),
    .o_key_err(o_key_err), .o_keys_ready(o_keys_ready), .i_key_flush(i_key_flush),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_data(i_in_data),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_data(o_out_data),
    .o_out_round(o_out_round), .o_out_last(o_out_last)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Advance one clock and apply the same edge to the model.
  task automatic tick();
    bit    idle, acc, pop, w_ok;
    beat_t b;
    idle = (m_round == 0) && (q.size() == 0);
    acc  = i_in_valid && m_keys_ready && ((q.size() == 0) || i_out_ready);
    pop  = (q.size() != 0) && i_out_ready;
    w_ok = i_key_wr_en && idle && (i_key_wr_idx <= 4'd10);
    b.d  = i_in_data ^ m_key[m_round];
    b.r  = m_round;
    @(posedge i_clk);
    #1;
    if (pop) void'(q.pop_front());
    if (acc) begin
      q.push_back(b);
      m_round = (m_round == 10) ? 0 : m_round + 1;
    end
    if (i_key_flush) m_mask = '0;
    else if (w_ok) begin
      m_mask[i_key_wr_idx] = 1'b1;
      m_key[i_key_wr_idx]  = i_key_wr_data;
    end
    m_keys_ready = &m_mask;
  endtask

  task automatic test_reset();
    #2;
    i_rst_n = 1'b0;
    #1;
    n_chk++;
    if ({o_out_valid, o_out_last, o_key_err, o_keys_ready, o_in_ready} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags got valid=%b last=%b err=%b kready=%b in_ready=%b want all 0",
               o_out_valid, o_out_last, o_key_err, o_keys_ready, o_in_ready);
    end
    n_chk++;
    if (o_out_data !== 128'd0 || o_out_round !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_data got data=%h round=%0d want 0/0", o_out_data, o_out_round);
    end
    #1;
    i_rst_n = 1'b1;
    q.delete();
    m_round = 0;
    m_mask = '0;
    m_keys_ready = 1'b0;
  endtask

  task automatic test_key_load();
    i_out_ready = 1'b1;
    i_in_valid  = 1'b1;
    i_in_data   = rand128();
    for (int k = 0; k <= 10; k++) begin
      i_key_wr_en   = 1'b1;
      i_key_wr_idx  = 4'(k);
      i_key_wr_data = (k == 1) ? KEY1 : rand128();
      n_chk++;
      if (o_in_ready !== 1'b0 || o_keys_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL key_load_early idx=%0d got in_ready=%b kready=%b want 0/0",
                 k, o_in_ready, o_keys_ready);
      end
      tick();
    end
    i_key_wr_en = 1'b0;
    i_in_valid  = 1'b0;
    n_chk++;
    if (o_keys_ready !== 1'b1 || o_in_ready !== 1'b1 || o_key_err !== 1'b0) begin
      n_fail++;
      $display("FAIL key_load_done got kready=%b in_ready=%b err=%b want 1/1/0",
               o_keys_ready, o_in_ready, o_key_err);
    end
  endtask

  task automatic test_known_vector();
    logic [127:0] d0;
    i_out_ready = 1'b1;
    i_in_valid  = 1'b1;
    d0          = rand128();
    i_in_data   = d0;
    tick();
    n_chk++;
    if (o_out_valid !== 1'b1 || o_out_round !== 4'd0 || o_out_data !== (d0 ^ m_key[0])) begin
      n_fail++;
      $display("FAIL vector_beat0 got v=%b r=%0d d=%h want 1/0/%h",
               o_out_valid, o_out_round, o_out_data, d0 ^ m_key[0]);
    end
    i_in_data = VEC_IN;
    tick();
    n_chk++;
    if (o_out_data !== VEC_OUT || o_out_round !== 4'd1 || o_out_last !== 1'b0) begin
      n_fail++;
      $display("FAIL vector_beat1 got d=%h r=%0d last=%b want %h/1/0",
               o_out_data, o_out_round, o_out_last, VEC_OUT);
    end
    i_in_valid = 1'b0;
    tick();
    n_chk++;
    if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL vector_drain got v=%b in_ready=%b want 0/1", o_out_valid, o_in_ready);
    end
  endtask

  task automatic test_busy_key_write();
    i_key_wr_en   = 1'b1;
    i_key_wr_idx  = 4'd3;
    i_key_wr_data = ~m_key[3];
    tick();
    i_key_wr_en = 1'b0;
    n_chk++;
    if (o_key_err !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_write_err got err=%b want 1", o_key_err);
    end
    tick();
    n_chk++;
    if (o_key_err !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_write_pulse got err=%b want 0", o_key_err);
    end
  endtask

  // Finishes the block left at round 2 with a 5-cycle output stall.
  task automatic test_stall();
    int sent, seen;
    logic [127:0] held;
    i_out_ready = 1'b0;
    i_in_valid  = 1'b1;
    i_in_data   = rand128();
    tick();
    sent = 1;
    seen = 0;
    held = q[0].d;
    for (int c = 0; c < 5; c++) begin
      i_in_data = rand128();
      n_chk++;
      if (o_in_ready !== 1'b0 || o_out_valid !== 1'b1 || o_out_data !== held || o_out_round !== 4'd2) begin
        n_fail++;
        $display("FAIL stall_hold c=%0d got in_ready=%b v=%b d=%h r=%0d want 0/1/%h/2",
                 c, o_in_ready, o_out_valid, o_out_data, o_out_round, held);
      end
      tick();
    end
    i_out_ready = 1'b1;
    for (int c = 0; c < 20 && (sent < 9 || q.size() != 0); c++) begin
      i_in_valid = (sent < 9);
      i_in_data  = rand128();
      if (q.size() != 0) begin
        n_chk++;
        if (o_out_valid !== 1'b1 || o_out_data !== q[0].d || o_out_round !== 4'(q[0].r) ||
            o_out_last !== (q[0].r == 10)) begin
          n_fail++;
          $display("FAIL stall_release c=%0d got v=%b d=%h r=%0d last=%b want 1/%h/%0d",
                   c, o_out_valid, o_out_data, o_out_round, o_out_last, q[0].d, q[0].r);
        end
      end
      if (o_out_valid && i_out_ready) seen++;
      if (i_in_valid) sent++;
      tick();
    end
    i_in_valid = 1'b0;
    n_chk++;
    if (seen !== 9 || o_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_count got beats=%0d v=%b want 9/0", seen, o_out_valid);
    end
  endtask

  task automatic test_back_to_back();
    i_out_ready = 1'b1;
    for (int c = 0; c <= 11; c++) begin
      i_in_valid = (c < 11);
      i_in_data  = rand128();
      if (c > 0) begin
        n_chk++;
        if (q.size() == 0 || o_out_valid !== 1'b1 || o_out_round !== 4'(c - 1) ||
            o_out_last !== (c - 1 == 10) || o_out_data !== q[0].d) begin
          n_fail++;
          $display("FAIL b2b c=%0d got v=%b r=%0d last=%b d=%h want 1/%0d/%b",
                   c, o_out_valid, o_out_round, o_out_last, o_out_data, c - 1, (c - 1 == 10));
        end
      end
      tick();
    end
    i_in_valid = 1'b0;
    n_chk++;
    if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_end got v=%b in_ready=%b want 0/1", o_out_valid, o_in_ready);
    end
  endtask

  // Back in IDLE after a full block: out-of-range index rejected, idx 10 accepted.
  task automatic test_idle_key_writes();
    i_key_wr_en   = 1'b1;
    i_key_wr_idx  = 4'd12;
    i_key_wr_data = rand128();
    tick();
    n_chk++;
    if (o_key_err !== 1'b1 || o_keys_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_bad_idx got err=%b kready=%b want 1/1", o_key_err, o_keys_ready);
    end
    i_key_wr_idx  = 4'd10;
    i_key_wr_data = rand128();
    tick();
    i_key_wr_en = 1'b0;
    n_chk++;
    if (o_key_err !== 1'b0 || o_keys_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_good_idx got err=%b kready=%b want 0/1", o_key_err, o_keys_ready);
    end
  endtask

  task automatic test_flush();
    i_out_ready = 1'b0;
    i_in_valid  = 1'b1;
    i_in_data   = rand128();
    tick();
    i_key_flush = 1'b1;
    tick();
    i_key_flush = 1'b0;
    n_chk++;
    if (o_keys_ready !== 1'b0 || o_in_ready !== 1'b0 || o_out_valid !== 1'b1 || o_out_data !== q[0].d) begin
      n_fail++;
      $display("FAIL flush_hold got kready=%b in_ready=%b v=%b d=%h want 0/0/1/%h",
               o_keys_ready, o_in_ready, o_out_valid, o_out_data, q[0].d);
    end
    i_out_ready = 1'b1;
    tick();
    i_in_valid = 1'b0;
    n_chk++;
    if (o_out_valid !== 1'b0 || o_in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_drain got v=%b in_ready=%b want 0/0", o_out_valid, o_in_ready);
    end
  endtask

  task automatic test_reset_mid_block();
    i_out_ready = 1'b1;
    i_in_valid  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      i_in_data = rand128();
      tick();
    end
    i_in_valid = 1'b0;
    n_chk++;
    if (o_out_valid !== 1'b1 || o_out_round !== 4'd4) begin
      n_fail++;
      $display("FAIL mid_block_round got v=%b r=%0d want 1/4", o_out_valid, o_out_round);
    end
    test_reset();
    tick();
    n_chk++;
    if (o_keys_ready !== 1'b0 || o_in_ready !== 1'b0 || o_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset got kready=%b in_ready=%b v=%b want 0/0/0",
               o_keys_ready, o_in_ready, o_out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_key_load();
    test_known_vector();
    test_busy_key_write();
    test_stall();
    test_back_to_back();
    test_idle_key_writes();
    test_flush();
    test_reset();
    test_key_load();
    test_reset_mid_block();
    test_key_load();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
